// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared constants and types for the music sequencer, note ROM and tone table
//
// Purpose : one place for the sequencer state encoding, the end-of-song marker,
//           the default song length and the bit positions of the two fields
//           packed into every note ROM entry.
// Ports   : none (package)
package music_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_SOUND = 2'd3
    } state_t;

    // Entry that terminates a song before the end of its ROM region.
    localparam logic [7:0] END_MARKER = 8'hF0;

    // ROM entries per song; each song occupies an aligned region of this size.
    localparam int SONG_LEN = 64;

    // ROM entry layout: [DUR_MSB:DUR_LSB] = duration-1 in ticks,
    //                   [NOTE_MSB:NOTE_LSB] = note index (0 = rest).
    localparam int NOTE_LSB = 0;
    localparam int NOTE_MSB = 3;
    localparam int DUR_LSB  = 4;
    localparam int DUR_MSB  = 7;

    function automatic logic [3:0] note_of(input logic [7:0] entry);
        return entry[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [3:0] dur_of(input logic [7:0] entry);
        return entry[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// rtl/music_sequencer_if.sv - control, ROM and tone-path signals of the music sequencer
//
// Purpose : bundles the user controls, the note ROM port and the outputs
//           towards the tone table into one interface.
// Signals : START/STOP (pulses), PAUSE/LOOP (levels), SONG_SEL[1:0],
//           ROM_DATA[7:0] (from ROM), ROM_ADDR[ADDR_W-1:0] (to ROM),
//           INX[3:0], NOTE_STB, BUSY, DONE (status / tone path).
// Modports: slave  - the sequencer itself
//           master - the environment (controls, ROM, tone table)
interface music_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              START;
    logic              STOP;
    logic              PAUSE;
    logic              LOOP;
    logic [1:0]        SONG_SEL;
    logic [7:0]        ROM_DATA;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic [3:0]        INX;
    logic              NOTE_STB;
    logic              BUSY;
    logic              DONE;

    modport slave (
        input  START, STOP, PAUSE, LOOP, SONG_SEL, ROM_DATA,
        output ROM_ADDR, INX, NOTE_STB, BUSY, DONE
    );

    modport master (
        output START, STOP, PAUSE, LOOP, SONG_SEL, ROM_DATA,
        input  ROM_ADDR, INX, NOTE_STB, BUSY, DONE
    );
endinterface

// File: rtl/tempo_div.sv
// rtl/tempo_div.sv - tempo tick generator, one tick every TICK_DIV enabled cycles
//
// Purpose : counts enabled clock cycles and emits a 1-cycle tick on the last
//           count of each TICK_DIV period.
// Ports   : CLK     - system clock
//           RST     - synchronous active-high reset
//           i_en    - count enable; the counter holds while low
//           i_clr   - synchronous clear back to count 0
//           o_tick  - high for the enabled cycle in which the count is TICK_DIV-1
module tempo_div #(
    parameter int TICK_DIV = 3000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Combinational so the sequencer sees the tick in the same cycle the
    // counter wraps; a held (disabled) counter never ticks.
    assign o_tick = i_en && w_last;

endmodule

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - steps through a synchronous note ROM at tempo rate
//
// Purpose : plays the song chosen by SONG_SEL: fetches note entries from the
//           ROM, holds each note index on INX for (dur+1) tempo ticks, and
//           handles stop, pause, loop and the end of a song.
// Ports   : CLK - system clock
//           RST - synchronous active-high reset
//           bus - music_sequencer_if.slave:
//                 START/STOP pulses, PAUSE/LOOP levels, SONG_SEL,
//                 ROM_DATA in / ROM_ADDR out, INX, NOTE_STB, BUSY, DONE out
module music_sequencer
    import music_pkg::*;
#(
    parameter int TICK_DIV = 3000000,
    parameter int SONG_LEN = music_pkg::SONG_LEN,
    parameter int ADDR_W   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    music_sequencer_if.slave    bus
);
    localparam int                OFF_W    = $clog2(SONG_LEN);
    localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(SONG_LEN - 1);

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_base,     w_base;
    logic [OFF_W-1:0]  r_offset,   w_offset;
    logic [ADDR_W-1:0] r_addr,     w_addr;
    logic [3:0]        r_inx,      w_inx;
    logic [3:0]        r_beat,     w_beat;
    logic              r_note_stb, w_note_stb;
    logic              r_busy,     w_busy;
    logic              r_done,     w_done;

    logic              w_end;
    logic              w_tick;
    logic [OFF_W-1:0]  w_off_inc;
    logic [ADDR_W-1:0] w_sel_base;

    // Songs live in aligned regions, so the song base is SONG_SEL with the
    // offset bits zeroed, and base|offset can never leave the region.
    assign w_sel_base = ADDR_W'({bus.SONG_SEL, {OFF_W{1'b0}}});
    assign w_off_inc  = r_offset + OFF_W'(1);

    tempo_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tempo_div (
        .CLK    (CLK),
        .RST    (RST),
        .i_en   ((r_state == S_SOUND) && !bus.PAUSE),
        .i_clr  (r_state != S_SOUND),
        .o_tick (w_tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_offset   <= '0;
            r_addr     <= '0;
            r_inx      <= '0;
            r_beat     <= '0;
            r_note_stb <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_base     <= w_base;
            r_offset   <= w_offset;
            r_addr     <= w_addr;
            r_inx      <= w_inx;
            r_beat     <= w_beat;
            r_note_stb <= w_note_stb;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_base     = r_base;
        w_offset   = r_offset;
        w_addr     = r_addr;
        w_inx      = r_inx;
        w_beat     = r_beat;
        w_note_stb = 1'b0;
        w_done     = 1'b0;
        w_busy     = r_busy;
        w_end      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_base   = w_sel_base;
                    w_addr   = w_sel_base;
                    w_offset = '0;
                    w_busy   = 1'b1;
                    w_next   = S_FETCH;
                end
            end

            // Address is on the ROM this cycle; INX keeps the previous note
            // so the speaker does not click between notes.
            S_FETCH: begin
                w_next = S_WAIT;
            end

            S_WAIT: begin
                if (bus.ROM_DATA == END_MARKER) begin
                    w_end = 1'b1;
                end else begin
                    w_inx      = note_of(bus.ROM_DATA);
                    w_beat     = dur_of(bus.ROM_DATA);
                    w_note_stb = 1'b1;
                    w_next     = S_SOUND;
                end
            end

            S_SOUND: begin
                if (w_tick) begin
                    if (r_beat != 4'd0) begin
                        w_beat = r_beat - 4'd1;
                    end else if (r_offset == LAST_OFF) begin
                        // Running off the region counts as an end marker.
                        w_end = 1'b1;
                    end else begin
                        w_offset = w_off_inc;
                        w_addr   = r_base | ADDR_W'(w_off_inc);
                        w_next   = S_FETCH;
                    end
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (w_end) begin
            if (bus.LOOP) begin
                w_offset = '0;
                w_addr   = r_base;
                w_next   = S_FETCH;
            end else begin
                w_inx  = 4'd0;
                w_done = 1'b1;
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        end

        // STOP overrides everything, including a START in the same cycle.
        if (bus.STOP) begin
            w_next     = S_IDLE;
            w_inx      = 4'd0;
            w_busy     = 1'b0;
            w_done     = 1'b0;
            w_note_stb = 1'b0;
        end
    end

    assign bus.ROM_ADDR = r_addr;
    // Pause silences the tone path without losing the loaded note.
    assign bus.INX      = ((r_state == S_SOUND) && bus.PAUSE) ? 4'd0 : r_inx;
    assign bus.NOTE_STB = r_note_stb;
    assign bus.BUSY     = r_busy;
    assign bus.DONE     = r_done;

endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - scoreboard bench for music_sequencer
module tb_music_sequencer;
    import music_pkg::*;

    localparam int T  = 4;
    localparam int SL = 64;
    localparam int AW = 8;

    typedef struct {
        bit       is_done;
        int       addr;
        int       inx;
        int       gap;
    } ev_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    music_sequencer_if #(.ADDR_W(AW)) bus ();

    music_sequencer #(
        .TICK_DIV (T),
        .SONG_LEN (SL),
        .ADDR_W   (AW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [7:0] rom [0:255];
    always_ff @(posedge CLK) bus.ROM_DATA <= rom[bus.ROM_ADDR];

    ev_t sb[$];
    int  checks;
    int  errors;
    int  cyc;
    int  last_evt;
    int  exp_base;

    task automatic monitor();
        ev_t e;
        int  a;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST) begin
                if (bus.START && !bus.STOP && !bus.BUSY) begin
                    last_evt = cyc;
                    exp_base = int'(bus.SONG_SEL) * SL;
                end
                if (bus.BUSY) begin
                    a = int'(bus.ROM_ADDR);
                    checks++;
                    if (a < exp_base || a > exp_base + SL - 1) begin
                        errors++;
                        $display("FAIL rom_addr_range: addr %0d outside %0d..%0d", a, exp_base, exp_base + SL - 1);
                    end
                end
                if (bus.NOTE_STB || bus.DONE) begin
                    checks++;
                    if (bus.NOTE_STB && bus.DONE) begin
                        errors++;
                        $display("FAIL stb_done_overlap: both high at cycle %0d", cyc);
                    end else if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: stb=%0b done=%0b inx=%0d at cycle %0d",
                                 bus.NOTE_STB, bus.DONE, bus.INX, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (bus.DONE !== e.is_done) begin
                            errors++;
                            $display("FAIL event_kind: done=%0b expected done=%0b", bus.DONE, e.is_done);
                        end
                        checks++;
                        if (cyc - last_evt !== e.gap) begin
                            errors++;
                            $display("FAIL event_gap: got %0d cycles expected %0d", cyc - last_evt, e.gap);
                        end
                        checks++;
                        if (e.is_done) begin
                            if (bus.BUSY !== 1'b0 || bus.INX !== 4'd0) begin
                                errors++;
                                $display("FAIL done_state: busy=%0b inx=%0d expected busy=0 inx=0", bus.BUSY, bus.INX);
                            end
                        end else begin
                            if (int'(bus.ROM_ADDR) !== e.addr || int'(bus.INX) !== e.inx || bus.BUSY !== 1'b1) begin
                                errors++;
                                $display("FAIL note_load: addr=%0d inx=%0d busy=%0b expected addr=%0d inx=%0d busy=1",
                                         bus.ROM_ADDR, bus.INX, bus.BUSY, e.addr, e.inx);
                            end
                        end
                    end
                    last_evt = cyc;
                end
            end
        end
    endtask

    // Independent walk of the ROM producing the expected NOTE_STB/DONE stream.
    // Gaps: START->first STB is 3; STB->next STB or DONE is (dur+1)*T+2;
    // a looped end marker costs 2 more; running off the region ends 2 sooner.
    task automatic expect_song(input int sel, input bit loop, input int max_notes,
                               input int pause_after, input int pause_len);
        ev_t        ev;
        int         base;
        int         off;
        int         extra;
        int         n;
        logic [7:0] e;
        base  = sel * SL;
        off   = 0;
        extra = 3;
        n     = 0;
        for (int guard = 0; guard < 300; guard++) begin
            e = rom[base + off];
            if (e == END_MARKER) begin
                if (loop) begin
                    extra += 2;
                    off = 0;
                    continue;
                end
                ev.is_done = 1'b1; ev.addr = 0; ev.inx = 0; ev.gap = extra;
                sb.push_back(ev);
                return;
            end
            if (n == max_notes) return;
            ev.is_done = 1'b0; ev.addr = base + off; ev.inx = int'(e[3:0]); ev.gap = extra;
            sb.push_back(ev);
            extra = (int'(e[7:4]) + 1) * T + 2 + ((n == pause_after) ? pause_len : 0);
            n++;
            if (off == SL - 1) begin
                if (loop) begin
                    off = 0;
                end else begin
                    ev.is_done = 1'b1; ev.addr = 0; ev.inx = 0; ev.gap = extra - 2;
                    sb.push_back(ev);
                    return;
                end
            end else begin
                off++;
            end
        end
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        @(posedge CLK); #1;
        bus.SONG_SEL = sel;
        bus.START    = 1'b1;
        @(posedge CLK); #1;
        bus.START    = 1'b0;
    endtask

    task automatic wait_level(input int budget, input int level, input bit need_idle, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge CLK); #1;
            if (sb.size() <= level && (!need_idle || !bus.BUSY)) break;
        end
        checks++;
        if (k == budget) begin
            errors++;
            $display("FAIL %s_timeout: %0d events pending, busy=%0b, required <=%0d pending", name, sb.size(), bus.BUSY, level);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.ROM_ADDR !== 8'd0 || bus.INX !== 4'd0 || bus.NOTE_STB !== 1'b0 ||
            bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%0d inx=%0d stb=%0b busy=%0b done=%0b required all 0",
                     bus.ROM_ADDR, bus.INX, bus.NOTE_STB, bus.BUSY, bus.DONE);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_basic();
        expect_song(0, 1'b0, 1000, -1, 0);
        pulse_start(2'd0);
        wait_level(200, 0, 1'b1, "basic");
        checks++;
        if (bus.INX !== 4'd0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: inx=%0d busy=%0b required 0 0", bus.INX, bus.BUSY);
        end
    endtask

    task automatic test_song_select();
        expect_song(2, 1'b0, 1000, -1, 0);
        pulse_start(2'd2);
        wait_level(2000, 0, 1'b1, "song_select");
    endtask

    task automatic test_loop();
        bus.LOOP = 1'b1;
        expect_song(0, 1'b1, 4, -1, 0);
        pulse_start(2'd0);
        wait_level(300, 0, 1'b0, "loop");
        @(posedge CLK); #1;
        bus.STOP = 1'b1;
        bus.LOOP = 1'b0;
        @(posedge CLK); #1;
        bus.STOP = 1'b0;
        repeat (10) @(negedge CLK);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop: busy=%0b required 0", bus.BUSY);
        end
    endtask

    task automatic test_pause();
        expect_song(0, 1'b0, 1000, 0, 10);
        pulse_start(2'd0);
        wait_level(50, 2, 1'b0, "pause_first");
        repeat (3) @(posedge CLK);
        #1 bus.PAUSE = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            checks++;
            if (bus.INX !== 4'd0) begin
                errors++;
                $display("FAIL pause_silence: inx=%0d required 0", bus.INX);
            end
            @(posedge CLK);
        end
        #1 bus.PAUSE = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.INX !== 4'd3) begin
            errors++;
            $display("FAIL pause_resume: inx=%0d required 3", bus.INX);
        end
        wait_level(200, 0, 1'b1, "pause");
    endtask

    task automatic test_stop_start();
        expect_song(0, 1'b0, 1, -1, 0);
        pulse_start(2'd0);
        wait_level(50, 0, 1'b0, "stop_first");
        @(posedge CLK); #1;
        bus.STOP     = 1'b1;
        bus.START    = 1'b1;
        bus.SONG_SEL = 2'd1;
        @(posedge CLK); #1;
        bus.STOP  = 1'b0;
        bus.START = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.INX !== 4'd0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL stop_start: inx=%0d busy=%0b done=%0b required 0 0 0", bus.INX, bus.BUSY, bus.DONE);
        end
        repeat (20) @(negedge CLK);
        expect_song(0, 1'b0, 1000, -1, 0);
        pulse_start(2'd0);
        wait_level(200, 0, 1'b1, "replay");
    endtask

    task automatic test_reset_mid();
        expect_song(0, 1'b0, 1, -1, 0);
        pulse_start(2'd0);
        wait_level(50, 0, 1'b0, "reset_first");
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (bus.ROM_ADDR !== 8'd0 || bus.INX !== 4'd0 || bus.NOTE_STB !== 1'b0 ||
            bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: addr=%0d inx=%0d stb=%0b busy=%0b done=%0b required all 0",
                     bus.ROM_ADDR, bus.INX, bus.NOTE_STB, bus.BUSY, bus.DONE);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_back_to_back();
        expect_song(0, 1'b0, 1000, -1, 0);
        pulse_start(2'd0);
        wait_level(50, 2, 1'b0, "b2b_first");
        pulse_start(2'd1);
        wait_level(200, 0, 1'b1, "b2b");
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        last_evt     = 0;
        exp_base     = 0;
        RST          = 1'b1;
        bus.START    = 1'b0;
        bus.STOP     = 1'b0;
        bus.PAUSE    = 1'b0;
        bus.LOOP     = 1'b0;
        bus.SONG_SEL = 2'd0;
        for (int i = 0; i < 256; i++) rom[i] = END_MARKER;
        rom[0] = 8'h13;
        rom[1] = 8'h05;
        rom[2] = 8'hF0;
        for (int k = 0; k < SL; k++) begin
            rom[2 * SL + k] = {3'b000, k[0], k[3:0]};
        end
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_song_select();
        test_loop();
        test_pause();
        test_stop_start();
        test_reset_mid();
        test_back_to_back();
        repeat (10) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d pending, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
